// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Holds the FSM encoding, funct3 codes and byte-enable decode.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WB,
    S_FAULT
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [3:0] be_for(
    input logic [2:0] funct3,
    input logic [1:0] addr_lo
  );
    logic [3:0] be;
    be = 4'b1111;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << addr_lo;
      2'b01:   be = 4'b0011 << addr_lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic f3_legal(
    input logic       load,
    input logic [2:0] funct3
  );
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = load;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] funct3,
    input logic [1:0] addr_lo
  );
    logic bad;
    bad = 1'b0;
    case (funct3[1:0])
      2'b01:   bad = addr_lo[0];
      2'b10:   bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Load lane extraction: picks the addressed byte/half
// from the read word and sign- or zero-extends it.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [31:0] w_lane;

  assign w_lane = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_data = w_lane;
    unique case (i_funct3)
      F3_B:    o_data = {{24{w_lane[7]}}, w_lane[7:0]};
      F3_H:    o_data = {{16{w_lane[15]}}, w_lane[15:0]};
      F3_BU:   o_data = {24'b0, w_lane[7:0]};
      F3_HU:   o_data = {16'b0, w_lane[15:0]};
      default: o_data = w_lane;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one request at a time over a
// req/gnt/rvalid bus, with a single-cycle writeback.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              reg_write,
  output logic [4:0]        write_reg,
  output logic [31:0]       mem_load_data,
  output logic              load_enable,
  output logic              lsu_fault,
  output logic              busy
);

  lsu_state_e r_state;
  lsu_state_e w_next;

  logic              r_load;
  logic [2:0]        r_f3;
  logic [1:0]        r_addr_lo;
  logic [4:0]        r_rd;
  logic [3:0]        r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_ldata;

  logic        w_accept;
  logic        w_bad;
  logic [31:0] w_aligned;

  assign w_accept = req_valid && (r_state == S_IDLE);
  assign w_bad    = !f3_legal(req_load, req_funct3)
                 || misaligned(req_funct3, req_addr[1:0]);

  load_align u_align (
    .i_rdata   (mem_rdata),
    .i_addr_lo (r_addr_lo),
    .i_funct3  (r_f3),
    .o_data    (w_aligned)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_bad ? S_FAULT : S_REQ;
      end
      S_REQ: begin
        if (mem_gnt) w_next = r_load ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (mem_rvalid) w_next = S_WB;
      end
      S_WB:    w_next = S_IDLE;
      S_FAULT: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Bus-side registers only load for legal requests so a
  // faulting access leaves the memory port untouched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_load    <= 1'b0;
      r_f3      <= '0;
      r_addr_lo <= '0;
      r_rd      <= '0;
      r_be      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else if (w_accept) begin
      r_load    <= req_load;
      r_f3      <= req_funct3;
      r_addr_lo <= req_addr[1:0];
      r_rd      <= req_rd;
      if (!w_bad) begin
        r_be    <= be_for(req_funct3, req_addr[1:0]);
        r_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
        r_wdata <= req_wdata << {req_addr[1:0], 3'b000};
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ldata <= '0;
    end else if (r_state == S_WAIT && mem_rvalid) begin
      r_ldata <= w_aligned;
    end
  end

  assign req_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign mem_req       = (r_state == S_REQ);
  assign mem_we        = mem_req && !r_load;
  assign mem_be        = r_be;
  assign mem_addr      = r_addr;
  assign mem_wdata     = r_wdata;
  assign load_enable   = (r_state == S_WB);
  assign reg_write     = load_enable && (r_rd != 5'd0);
  assign write_reg     = r_rd;
  assign mem_load_data = r_ldata;
  assign lsu_fault     = (r_state == S_FAULT);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a writeback
// scoreboard fed at request time and drained at WB.
module tb_load_store_unit;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] mem_load_data;
  logic        load_enable;
  logic        lsu_fault;
  logic        busy;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
  } wb_t;

  wb_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  n_fault = 0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_load      (req_load),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_rd        (req_rd),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_be        (mem_be),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .reg_write     (reg_write),
    .write_reg     (write_reg),
    .mem_load_data (mem_load_data),
    .load_enable   (load_enable),
    .lsu_fault     (lsu_fault),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Writeback scoreboard: every WB cycle must match the head.
  always @(negedge clock) begin
    if (!reset && (load_enable || reg_write)) begin
      check("wb_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        wb_t e;
        e = exp_q.pop_front();
        check("sb_rd", write_reg, e.rd);
        check("sb_data", mem_load_data, e.data);
        check("sb_we", reg_write, e.we);
        check("sb_le", load_enable, 1);
      end
    end
    if (!reset && lsu_fault) n_fault++;
  end

  task automatic accept(
    input logic        ld,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [4:0]  rd
  );
    int k;
    k = 0;
    req_valid  = 1'b1;
    req_load   = ld;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_rd     = rd;
    while (!req_ready && k < 20) begin
      tick();
      k++;
    end
    check("accept_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_load(
    input string       tag,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [3:0]  be,
    input logic [31:0] rdata,
    input logic [4:0]  rd,
    input logic [31:0] exp
  );
    wb_t e;
    e.rd   = rd;
    e.data = exp;
    e.we   = (rd != 5'd0);
    exp_q.push_back(e);
    accept(1'b1, f3, a, 32'h0, rd);
    check({tag, "_req"}, mem_req, 1);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_be"}, mem_be, be);
    check({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    check({tag, "_wait_noreq"}, mem_req, 0);
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    check({tag, "_le"}, load_enable, 1);
    check({tag, "_rw"}, reg_write, rd != 5'd0);
    check({tag, "_rd"}, write_reg, rd);
    check({tag, "_data"}, mem_load_data, exp);
    tick();
    check({tag, "_pulse_end"}, load_enable, 0);
    check({tag, "_ready"}, req_ready, 1);
  endtask

  initial begin
    int f0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_load   = 1'b0;
    req_funct3 = 3'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_rd     = 5'd0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    #12;
    check("rst_ready", req_ready, 1);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_be", mem_be, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rw", reg_write, 0);
    check("rst_wreg", write_reg, 0);
    check("rst_ldata", mem_load_data, 0);
    check("rst_le", load_enable, 0);
    check("rst_fault", lsu_fault, 0);
    check("rst_busy", busy, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();

    do_load("lw", 3'b010, 32'h100, 4'b1111,
            32'hDEADBEEF, 5'd5, 32'hDEADBEEF);
    do_load("lb", 3'b000, 32'h103, 4'b1000,
            32'h80FF0000, 5'd6, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 32'h103, 4'b1000,
            32'h80FF0000, 5'd7, 32'h00000080);
    do_load("lhu", 3'b101, 32'h102, 4'b1100,
            32'h80FF0000, 5'd8, 32'h000080FF);
    do_load("lh", 3'b001, 32'h102, 4'b1100,
            32'h80FF0000, 5'd9, 32'hFFFF80FF);
    do_load("lb1", 3'b000, 32'h101, 4'b0010,
            32'h12345678, 5'd10, 32'h00000056);
    do_load("lw_x0", 3'b010, 32'h104, 4'b1111,
            32'hCAFEF00D, 5'd0, 32'hCAFEF00D);

    // SH with a slow grant: bus must stay frozen.
    accept(1'b0, 3'b001, 32'h202, 32'h00001234, 5'd3);
    for (int i = 0; i < 5; i++) begin
      check("sh_req", mem_req, 1);
      check("sh_we", mem_we, 1);
      check("sh_be", mem_be, 4'b1100);
      check("sh_addr", mem_addr, 32'h200);
      check("sh_wdata", mem_wdata, 32'h12340000);
      check("sh_noready", req_ready, 0);
      if (i == 4) mem_gnt = 1'b1;
      tick();
    end
    mem_gnt = 1'b0;
    check("sh_ready", req_ready, 1);
    check("sh_norw", reg_write, 0);
    check("sh_nole", load_enable, 0);
    check("sh_noreq", mem_req, 0);

    accept(1'b0, 3'b000, 32'h201, 32'h000000AB, 5'd4);
    check("sb_be", mem_be, 4'b0010);
    check("sb_wdata", mem_wdata, 32'h0000AB00);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("sb_ready", req_ready, 1);

    f0 = n_fault;
    accept(1'b1, 3'b010, 32'h101, 32'h0, 5'd11);
    check("mis_fault", lsu_fault, 1);
    check("mis_req", mem_req, 0);
    check("mis_rw", reg_write, 0);
    tick();
    check("mis_fault_end", lsu_fault, 0);
    check("mis_ready", req_ready, 1);
    check("mis_count", n_fault, f0 + 1);

    f0 = n_fault;
    accept(1'b1, 3'b011, 32'h100, 32'h0, 5'd12);
    check("ill_fault", lsu_fault, 1);
    check("ill_req", mem_req, 0);
    tick();
    check("ill_count", n_fault, f0 + 1);

    f0 = n_fault;
    accept(1'b0, 3'b100, 32'h100, 32'h55, 5'd0);
    check("st_ill_fault", lsu_fault, 1);
    check("st_ill_req", mem_req, 0);
    tick();
    check("st_ill_count", n_fault, f0 + 1);

    // Reset lands while the load waits for read data.
    accept(1'b1, 3'b010, 32'h300, 32'h0, 5'd13);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check("rw_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("rw_ready", req_ready, 1);
    check("rw_req", mem_req, 0);
    check("rw_busy0", busy, 0);
    check("rw_be", mem_be, 0);
    check("rw_addr", mem_addr, 0);
    check("rw_wreg", write_reg, 0);
    check("rw_ldata", mem_load_data, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11112222;
    tick();
    reset = 1'b0;
    tick();
    mem_rvalid = 1'b0;
    check("rw_post_rw", reg_write, 0);
    check("rw_post_le", load_enable, 0);
    check("rw_post_ready", req_ready, 1);
    tick();
    check("rw_post2_le", load_enable, 0);

    do_load("lw_after", 3'b010, 32'h400, 4'b1111,
            32'h0BADCAFE, 5'd31, 32'h0BADCAFE);
    tick();
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
